// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor-0 for the pipelined MIPS core.
// Holds BadVAddr, Count, Compare, SR, Cause, EPC and PrID.
// Arbitrates hardware, timer and software interrupts against synchronous exceptions.
// Raises Req to the flush logic and supplies EPC for eret.
module cp0_ext #(
    parameter int          NUM_HWINT  = 6,
    parameter int          SYNC_HWINT = 1,
    parameter int          PRESCALE   = 2,
    parameter int          TIMER_EN   = 1,
    parameter logic [31:0] PRID       = 32'h4D495053,
    parameter logic [31:0] EXC_ENTRY  = 32'h00004180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WE,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    input  logic [31:0]          DIn,
    output logic [31:0]          DOut,
    input  logic                 BDIn,
    input  logic [31:0]          VPC,
    input  logic [31:0]          BadVAddrIn,
    input  logic [4:0]           ExcCodeIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLClr,
    output logic                 Req,
    output logic [31:0]          EPCOut,
    output logic [31:0]          HandlerPC,
    output logic                 IntPending
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_COUNT    = 5'd9;
    localparam logic [4:0] R_COMPARE  = 5'd11;
    localparam logic [4:0] R_SR       = 5'd12;
    localparam logic [4:0] R_CAUSE    = 5'd13;
    localparam logic [4:0] R_EPC      = 5'd14;
    localparam logic [4:0] R_PRID     = 5'd15;

    logic [31:0]          r_badvaddr;
    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic [31:0]          r_epc;
    logic [7:0]           r_im;
    logic                 r_exl;
    logic                 r_ie;
    logic                 r_bd;
    logic [5:0]           r_ip_hw;
    logic [1:0]           r_swip;
    logic [4:0]           r_exccode;
    logic                 r_ti;
    logic [PW-1:0]        r_pre;

    logic [NUM_HWINT-1:0] w_hw;
    logic [5:0]           w_hw6;
    logic [7:0]           w_intsrc;
    logic                 w_tick;
    logic                 w_wr_count;
    logic                 w_wr_compare;
    logic                 w_wr_sr;
    logic                 w_wr_cause;
    logic                 w_wr_epc;
    logic [31:0]          w_count_nxt;
    logic [31:0]          w_sr;
    logic [31:0]          w_cause;
    logic                 w_int_pending;
    logic                 w_int_req;
    logic                 w_exc_req;
    logic                 w_req;

    generate
        if (SYNC_HWINT != 0) begin : g_sync
            logic [NUM_HWINT-1:0] r_sync1;
            logic [NUM_HWINT-1:0] r_sync2;
            // Two-flop synchroniser for the asynchronous interrupt lines.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= HWInt;
                    r_sync2 <= r_sync1;
                end
            end
            assign w_hw = r_sync2;
        end else begin : g_direct
            assign w_hw = HWInt;
        end
    endgenerate

    assign w_wr_count   = WE && (A2 == R_COUNT);
    assign w_wr_compare = WE && (A2 == R_COMPARE);
    assign w_wr_sr      = WE && (A2 == R_SR);
    assign w_wr_cause   = WE && (A2 == R_CAUSE);
    assign w_wr_epc     = WE && (A2 == R_EPC);

    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    // Interrupt source vector and request decode; outputs held low during reset.
    always_comb begin
        w_hw6                  = '0;
        w_hw6[NUM_HWINT-1:0]   = w_hw;
        w_intsrc      = {w_hw6[5] | r_ti, w_hw6[4:0], r_swip};
        w_int_pending = reset & (|(w_intsrc & r_im));
        w_int_req     = w_int_pending & r_ie & ~r_exl;
        w_exc_req     = reset & (ExcCodeIn != 5'd0) & ~r_exl;
        w_req         = w_int_req | w_exc_req;
    end

    // Next Count value: an mtc0 load takes precedence over the prescaled increment.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = DIn;
        end else if (w_tick) begin
            w_count_nxt = r_count + 32'd1;
        end
    end

    // Prescaler and Count; loading Count restarts the prescale period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr_count || w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // Compare and the sticky timer interrupt; a Compare write beats a same-cycle match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare <= DIn;
            r_ti      <= 1'b0;
        end else if ((TIMER_EN != 0) && (r_compare != 32'd0) && (w_count_nxt == r_compare)) begin
            r_ti      <= 1'b1;
        end
    end

    // Status register fields; exception entry beats eret, which beats an mtc0 to EXL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im  <= '0;
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
        end else begin
            if (w_wr_sr) begin
                r_im <= DIn[15:8];
                r_ie <= DIn[0];
            end
            if (w_req) begin
                r_exl <= 1'b1;
            end else if (EXLClr) begin
                r_exl <= 1'b0;
            end else if (w_wr_sr) begin
                r_exl <= DIn[1];
            end
        end
    end

    // Cause: pending bits tracked every cycle, software bits only on mtc0, BD/ExcCode on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ip_hw   <= '0;
            r_swip    <= '0;
            r_bd      <= 1'b0;
            r_exccode <= '0;
        end else begin
            r_ip_hw <= w_intsrc[7:2];
            if (w_wr_cause) begin
                r_swip <= DIn[9:8];
            end
            if (w_req) begin
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
            end
        end
    end

    // EPC and BadVAddr capture on entry; entry overrides a same-cycle EPC write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else if (w_req) begin
            r_epc      <= BDIn ? (VPC - 32'd4) : VPC;
            r_badvaddr <= BadVAddrIn;
        end else if (w_wr_epc) begin
            r_epc      <= DIn;
        end
    end

    assign w_sr    = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip_hw, r_swip, 1'b0, r_exccode, 2'b00};

    // Combinational register read port.
    always_comb begin
        case (A1)
            R_BADVADDR: DOut = r_badvaddr;
            R_COUNT:    DOut = r_count;
            R_COMPARE:  DOut = r_compare;
            R_SR:       DOut = w_sr;
            R_CAUSE:    DOut = w_cause;
            R_EPC:      DOut = r_epc;
            R_PRID:     DOut = PRID;
            default:    DOut = 32'd0;
        endcase
    end

    assign Req        = w_req;
    assign IntPending = w_int_pending;
    assign EPCOut     = r_epc;
    assign HandlerPC  = EXC_ENTRY;

endmodule

// File: tb/tb_cp0_ext.sv
// Scoreboard bench for cp0_ext: default-parameter instance plus a narrow,
// unsynchronised, PRESCALE=1 instance.
module tb_cp0_ext;
    localparam logic [31:0] PRID_V  = 32'h4D495053;
    localparam logic [31:0] ENTRY_V = 32'h00004180;

    typedef struct {
        string       name;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        WE = 1'b0;
    logic [4:0]  A1 = '0;
    logic [4:0]  A2 = '0;
    logic [31:0] DIn = '0;
    logic [31:0] DOut;
    logic        BDIn = 1'b0;
    logic [31:0] VPC = '0;
    logic [31:0] BadVAddrIn = '0;
    logic [4:0]  ExcCodeIn = '0;
    logic [5:0]  HWInt = '0;
    logic        EXLClr = 1'b0;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        IntPending;

    logic        we2 = 1'b0;
    logic [4:0]  a1_2 = '0;
    logic [4:0]  a2_2 = '0;
    logic [31:0] din2 = '0;
    logic [1:0]  hw2 = '0;
    logic [31:0] dout2;
    logic        req2;
    logic [31:0] epc2;
    logic [31:0] hpc2;
    logic        ip2;

    always #5 clk = ~clk;

    cp0_ext u_dut (
        .clk(clk), .reset(rst_n), .WE(WE), .A1(A1), .A2(A2), .DIn(DIn), .DOut(DOut),
        .BDIn(BDIn), .VPC(VPC), .BadVAddrIn(BadVAddrIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut),
        .HandlerPC(HandlerPC), .IntPending(IntPending)
    );

    cp0_ext #(.NUM_HWINT(2), .SYNC_HWINT(0), .PRESCALE(1)) u_dut2 (
        .clk(clk), .reset(rst_n), .WE(we2), .A1(a1_2), .A2(a2_2), .DIn(din2), .DOut(dout2),
        .BDIn(1'b0), .VPC(32'd0), .BadVAddrIn(32'd0), .ExcCodeIn(5'd0),
        .HWInt(hw2), .EXLClr(1'b0), .Req(req2), .EPCOut(epc2),
        .HandlerPC(hpc2), .IntPending(ip2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        WE = 1'b1; A2 = idx; DIn = data;
        tick();
        WE = 1'b0;
    endtask

    task automatic push(input string name, input logic [4:0] idx, input logic [31:0] val);
        exp_t e;
        e.name = name; e.idx = idx; e.val = val;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        #1 rst_n = 1'b0;
        ExcCodeIn = 5'd3;
        #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", Req); end
        checks++; if (IntPending !== 1'b0) begin errors++; $display("FAIL reset_intpending: got %b want 0", IntPending); end
        checks++; if (HandlerPC !== ENTRY_V) begin errors++; $display("FAIL handler_pc: got %h want %h", HandlerPC, ENTRY_V); end
        push("reset_sr", 5'd12, 32'h00400000);
        push("reset_prid", 5'd15, PRID_V);
        push("reset_count", 5'd9, 32'd0);
        push("reset_cause", 5'd13, 32'd0);
        push("reset_epc", 5'd14, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        ExcCodeIn = 5'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // Mid-run asynchronous reset with Count=0x55 and EXL=1.
        wr(5'd9, 32'h55);
        wr(5'd12, 32'h2);
        push("pre_reset_count", 5'd9, 32'h55);
        push("pre_reset_sr", 5'd12, 32'h00400002);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        ExcCodeIn = 5'd7;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL async_reset_req: got %b want 0", Req); end
        push("async_reset_sr", 5'd12, 32'h00400000);
        push("async_reset_count", 5'd9, 32'd0);
        push("async_reset_prid", 5'd15, PRID_V);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        ExcCodeIn = 5'd0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timer();
        exp_t e;
        wr(5'd9, 32'h100);
        wr(5'd11, 32'd5);
        wr(5'd12, 32'h8001);
        VPC = 32'h500;
        wr(5'd9, 32'd0);
        repeat (9) tick();
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL timer_early_req: got %b want 0", Req); end
        push("timer_count4", 5'd9, 32'd4);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        tick();
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL timer_req: got %b want 1", Req); end
        push("timer_count5", 5'd9, 32'd5);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        tick();
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL timer_masked_exl: got %b want 0", Req); end
        checks++; if (EPCOut !== 32'h500) begin errors++; $display("FAIL timer_epcout: got %h want %h", EPCOut, 32'h500); end
        push("timer_sr", 5'd12, 32'h00408003);
        push("timer_cause", 5'd13, 32'h00008000);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        repeat (3) tick();
        checks++; if (IntPending !== 1'b1) begin errors++; $display("FAIL timer_sticky: got %b want 1", IntPending); end
        wr(5'd11, 32'h1000);
        checks++; if (IntPending !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b want 0", IntPending); end
        push("timer_cause_lag", 5'd13, 32'h00008000);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        tick();
        push("timer_cause_clear", 5'd13, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        push("timer_eret_sr", 5'd12, 32'h00408001);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
    endtask

    task automatic test_hwint();
        exp_t e;
        wr(5'd12, 32'h0401);
        VPC = 32'h2000;
        HWInt = 6'b000001;
        tick();
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL hw_sync_lat1: got %b want 0", Req); end
        tick();
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL hw_req: got %b want 1", Req); end
        HWInt = 6'b000000;
        tick();
        checks++; if (EPCOut !== 32'h2000) begin errors++; $display("FAIL hw_epc: got %h want %h", EPCOut, 32'h2000); end
        push("hw_cause", 5'd13, 32'h00000400);
        push("hw_sr", 5'd12, 32'h00400403);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        wr(5'd12, 32'h0400);
        HWInt = 6'b000001;
        tick(); tick();
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL hw_ie0_req: got %b want 0", Req); end
        checks++; if (IntPending !== 1'b1) begin errors++; $display("FAIL hw_ie0_pending: got %b want 1", IntPending); end
        HWInt = 6'b000000;
        tick(); tick();
        checks++; if (IntPending !== 1'b0) begin errors++; $display("FAIL hw_release: got %b want 0", IntPending); end
    endtask

    task automatic test_exc();
        exp_t e;
        ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h3008; BadVAddrIn = 32'hDEAD0000;
        #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", Req); end
        tick();
        ExcCodeIn = 5'd5; BDIn = 1'b0; VPC = 32'h9000; BadVAddrIn = 32'h11112222;
        #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL exc_nested_req: got %b want 0", Req); end
        push("exc_epc", 5'd14, 32'h3004);
        push("exc_cause", 5'd13, 32'h80000010);
        push("exc_badvaddr", 5'd8, 32'hDEAD0000);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        tick();
        push("exc_nested_epc", 5'd14, 32'h3004);
        push("exc_nested_badvaddr", 5'd8, 32'hDEAD0000);
        push("exc_nested_cause", 5'd13, 32'h80000010);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        ExcCodeIn = 5'd0;
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        wr(5'd12, 32'h0401);
        HWInt = 6'b000001;
        tick(); tick();
        ExcCodeIn = 5'd12; VPC = 32'h4000; BadVAddrIn = 32'hBEEF0004;
        WE = 1'b1; A2 = 5'd14; DIn = 32'h1234; EXLClr = 1'b1;
        #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", Req); end
        tick();
        WE = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'b000000;
        push("prio_epc", 5'd14, 32'h4000);
        push("prio_sr_exl", 5'd12, 32'h00400403);
        push("prio_cause", 5'd13, 32'h00000400);
        push("prio_badvaddr", 5'd8, 32'hBEEF0004);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        WE = 1'b1; A2 = 5'd12; DIn = 32'h2; EXLClr = 1'b1;
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        push("eret_vs_write_sr", 5'd12, 32'h00400000);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
    endtask

    task automatic test_regs();
        exp_t e;
        wr(5'd9, 32'hFFFFFFFF);
        tick();
        push("wrap_hold", 5'd9, 32'hFFFFFFFF);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        tick();
        push("wrap_zero", 5'd9, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        wr(5'd15, 32'd0);
        wr(5'd8, 32'h77);
        push("prid_ro", 5'd15, PRID_V);
        push("badvaddr_ro", 5'd8, 32'hBEEF0004);
        push("unmapped_3", 5'd3, 32'd0);
        push("unmapped_10", 5'd10, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        wr(5'd13, 32'hFFFF0300);
        push("sw_ip_cause", 5'd13, 32'h00000300);
        while (sb.size() > 0) begin
            e = sb.pop_front(); A1 = e.idx; #1;
            checks++; if (DOut !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, DOut, e.val); end
        end
        checks++; if (IntPending !== 1'b0) begin errors++; $display("FAIL sw_masked: got %b want 0", IntPending); end
        wr(5'd12, 32'h0100);
        checks++; if (IntPending !== 1'b1) begin errors++; $display("FAIL sw_pending: got %b want 1", IntPending); end
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL sw_ie0_req: got %b want 0", Req); end
        wr(5'd13, 32'd0);
        checks++; if (IntPending !== 1'b0) begin errors++; $display("FAIL sw_cleared: got %b want 0", IntPending); end
    endtask

    task automatic test_narrow();
        we2 = 1'b1; a2_2 = 5'd9; din2 = 32'h10;
        tick();
        we2 = 1'b0;
        a1_2 = 5'd9; #1;
        checks++; if (dout2 !== 32'h10) begin errors++; $display("FAIL narrow_count_load: got %h want %h", dout2, 32'h10); end
        tick();
        checks++; if (dout2 !== 32'h11) begin errors++; $display("FAIL narrow_prescale1: got %h want %h", dout2, 32'h11); end
        hw2 = 2'b11;
        tick();
        a1_2 = 5'd13; #1;
        checks++; if (dout2 !== 32'h00000C00) begin errors++; $display("FAIL narrow_cause_ip: got %h want %h", dout2, 32'h00000C00); end
        checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL narrow_req: got %b want 0", req2); end
        checks++; if (ip2 !== 1'b0) begin errors++; $display("FAIL narrow_pending: got %b want 0", ip2); end
        checks++; if (epc2 !== 32'd0) begin errors++; $display("FAIL narrow_epc: got %h want 0", epc2); end
        checks++; if (hpc2 !== ENTRY_V) begin errors++; $display("FAIL narrow_handler: got %h want %h", hpc2, ENTRY_V); end
        hw2 = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_timer();
        test_hwint();
        test_exc();
        test_back_to_back();
        test_regs();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_ext.md
Name: cp0_ext

Overview:
- Parametrised coprocessor-0 for the pipelined MIPS core. Holds BadVAddr, Count, Compare, SR, Cause, EPC and PrID.
- Arbitrates hardware, timer and software interrupts against synchronous exceptions. Raises Req to the pipeline flush logic and supplies EPC for eret.
- Generalises the existing CP0:
  - configurable hardware interrupt line count
  - optional input synchroniser
  - programmable Count prescaler
  - sticky MIPS-style timer interrupt, cleared by a Compare write
  - configurable PrID and exception entry address

Parameters:
NUM_HWINT, 6, hardware interrupt lines (1..6); line k maps to IP[k+2]; unused IP bits read 0
SYNC_HWINT, 1, 1 = two-flop synchroniser on HWInt (+2 cycles latency); 0 = direct
PRESCALE, 2, clocks per Count increment (>=1)
TIMER_EN, 1, 0 = TI never set; Count still runs
PRID, 32'h4D495053, reset/read value of PrID
EXC_ENTRY, 32'h00004180, value driven on HandlerPC

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
WE  input  1  mtc0 write enable
A1  input  5  read register index
A2  input  5  write register index
DIn  input  32  mtc0 data
DOut  output  32  read data, combinational
BDIn  input  1  faulting instruction is in a delay slot
VPC  input  32  PC of the faulting/interrupted instruction
BadVAddrIn  input  32  faulting address
ExcCodeIn  input  5  exception code; 0 = none
HWInt  input  NUM_HWINT  level-sensitive hardware interrupts
EXLClr  input  1  eret: clear EXL
Req  output  1  take exception/interrupt this cycle
EPCOut  output  32  current EPC
HandlerPC  output  32  EXC_ENTRY, constant
IntPending  output  1  any unmasked source pending, ignoring IE/EXL

Behaviour:
- Reset (reset=0, async): all state is cleared as follows.
  - BadVAddr=0, Count=0, Compare=0, Cause=0, EPC=0, prescaler=0, synchroniser flops=0.
  - SR=32'h00400000 (Bev=1, IE=0, EXL=0, IM=0); PrID=PRID.
  - Req and IntPending are forced 0 while reset=0.
- Register map for reads: 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PrID. DOut is 0 for all other indices.
- Writable fields:
  - SR[15:8] (IM), SR[1:0] (EXL, IE)
  - Cause[9:8] (software IP)
  - Count, Compare, EPC
  - BadVAddr and PrID are read-only; writes to them are ignored.
- Interrupt sources: Intsrc[7:0] = {hw_s[5]|TI, hw_s[4:0], Cause[9:8]}. hw_s is HWInt after the optional synchroniser, zero-extended to 6 bits.
- IP update: Cause[15:8] <= Intsrc every cycle. Software bits 9:8 are written on mtc0 only; they hold otherwise.
- Request decode:
  - IntPending = |(Intsrc & IM)
  - IntReq = IntPending & IE & ~EXL
  - ExcReq = (ExcCodeIn != 0) & ~EXL
  - Req = IntReq | ExcReq, combinational
- On Req, at the clock edge:
  - EPC <= BDIn ? VPC-4 : VPC
  - BD <= BDIn
  - EXL <= 1
  - BadVAddr <= BadVAddrIn
  - ExcCode <= IntReq ? 0 : ExcCodeIn (interrupt has priority over exception)
- Simultaneous events:
  - Req overrides an mtc0 to SR/Cause/EPC in the same cycle. Non-overlapping fields of that write still apply.
  - Req together with EXLClr leaves EXL=1.
  - EXLClr together with a write to SR[1] leaves EXL=0.
- Prescaler and Count:
  - The prescaler counts 0..PRESCALE-1. Count += 1 (mod 2^32) in the cycle the prescaler equals PRESCALE-1.
  - With PRESCALE=1, Count increments every cycle.
  - An mtc0 to Count loads DIn and resets the prescaler to 0; no increment that cycle.
- Timer interrupt (TIMER_EN=1):
  - TI is set (sticky) on the cycle Count's next value equals Compare and Compare != 0.
  - TI is cleared only by an mtc0 to Compare. The write wins over a same-cycle match.
  - Count wrap-around does not clear TI.
- ExcCodeIn is sampled only when Req=1. While EXL=1, all exceptions and interrupts are masked.

Test Plan:
- Reset: drop reset low mid-run with Count=0x55 and EXL=1 -> asynchronously SR=0x00400000, Count=0, EXL=0, Req=0, DOut(A1=15)=PRID.
- Timer: PRESCALE=2; write Compare=5, SR=0x8001 -> TI sets after 10 clocks and Req=1 with ExcCode=0. TI stays set until Compare is written; it then clears the next cycle.
- Hardware interrupt: SYNC_HWINT=1, SR=0x0401, pulse HWInt[0] high -> Req asserts 2 cycles later and EPC=VPC. With IE=0, Req=0 but IntPending=1.
- Delay-slot exception: ExcCodeIn=4, BDIn=1, VPC=0x3008 -> EPC=0x3004, BD=1, ExcCode=4, BadVAddr latched. A second exception while EXL=1 -> Req=0.
- Priority and collision: ExcCodeIn=12 in the same cycle as an unmasked interrupt -> ExcCode=0. mtc0 EPC=0x1234 in the same cycle as Req -> EPC=VPC. Req with EXLClr -> EXL=1.
- Register access: write Count=0xFFFFFFFF -> wraps to 0 after PRESCALE clocks. Write PrID -> unchanged. Read A1=3 -> 0. NUM_HWINT=2 -> IP[7:4] read 0 unless TI.
